// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM data-port arbiter: master ids, arbiter state and request payload.
package ram_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;

  typedef logic master_id_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_arb_grant.sv
// Combinational grant select for the two RAM masters.
// Tie policy: round-robin when ARB_ROUND_ROBIN_EN is defined, else fixed m0 priority.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  arb_state_t             state_i,
  input  master_id_t             owner_i,
  input  master_id_t             last_i,
  input  logic                   cnt_full_i,
  output master_id_t             g_o,
  output logic                   grant_vld_o
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    grant_vld_o = |req_i;
    g_o         = 1'b0;
    if (state_i == ARB_LOCKED && req_i[owner_i] && !cnt_full_i) begin
      g_o = owner_i;
    end else if (req_i == 2'b10) begin
      g_o = 1'b1;
    end else if (req_i == 2'b01) begin
      g_o = 1'b0;
    end else if (req_i == 2'b11) begin
      // An exhausted burst always hands over to the waiting master.
      if (state_i == ARB_LOCKED && cnt_full_i) begin
        g_o = ~owner_i;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        g_o = ~last_i;
`else
        g_o = 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/ram_data_arbiter.sv
// Shares the RAM data port between the core LSU (m0) and the debug/DMA loader (m1),
// with bounded locked bursts. Tie policy selected by ARB_ROUND_ROBIN_EN.
module ram_data_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [BE_W-1:0]   m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [BE_W-1:0]   m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_require,
  output logic              ram_we,
  output logic [BE_W-1:0]   ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  master_id_t       owner_q, owner_d;
  master_id_t       last_q, last_d;
  master_id_t       rd_id_q, rd_id_d;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ram_req_t         req0, req1, sel;
  master_id_t       g;
  logic             grant_vld;
  logic             accept;
  logic             cnt_full;
  logic             lock_g;

  assign req0     = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
  assign req1     = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};
  assign cnt_full = (cnt_q >= CNT_W'(MAX_BURST));

  ram_arb_grant u_grant (
    .req_i       ({m1_req, m0_req}),
    .state_i     (state_q),
    .owner_i     (owner_q),
    .last_i      (last_q),
    .cnt_full_i  (cnt_full),
    .g_o         (g),
    .grant_vld_o (grant_vld)
  );

  // g is 0 when nobody requests, so the idle bus shows m0's fields.
  assign accept = grant_vld & reset;
  assign sel    = g ? req1 : req0;
  assign lock_g = g ? m1_lock : m0_lock;

  assign ram_require = accept;
  assign ram_we      = sel.we;
  assign ram_be      = sel.be;
  assign ram_addr    = sel.addr;
  assign ram_wdata   = sel.wdata;

  assign m0_ack    = accept & (g == 1'b0);
  assign m1_ack    = accept & (g == 1'b1);
  assign m0_rvalid = rd_pend_q & reset & (rd_id_q == 1'b0);
  assign m1_rvalid = rd_pend_q & reset & (rd_id_q == 1'b1);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ARB_OPEN;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      rd_id_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_id_q   <= rd_id_d;
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
    end
  end

  // Lock/burst FSM and response tag.
  always_comb begin
    state_d   = ARB_OPEN;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = '0;
    rd_pend_d = accept & ~sel.we;
    rd_id_d   = g;
    if (accept) begin
      last_d = g;
      if (state_q == ARB_LOCKED && cnt_full && g != owner_q) begin
        state_d = ARB_OPEN;
        cnt_d   = '0;
      end else if (lock_g) begin
        state_d = ARB_LOCKED;
        owner_d = g;
        if (state_q == ARB_LOCKED && g == owner_q) begin
          cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
    end
  end

endmodule
